// File: rtl/uart_pkg.sv
// ============================================================================
//  Module : uart_pkg
//  Brief  : Shared UART definitions: FSM encoding, line levels, bit timing.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int DATA_BITS = 8;

    // Integer divide: any fractional remainder becomes baud-rate error.
    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
// ============================================================================
//  Module : uart_tx_serializer_if
//  Brief  : Byte handshake plus serial line between UART registers and TX pin.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_serializer_if;

    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx
    );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module : uart_baud_tick
//  Brief  : Bit-period counter; bit_tick_o marks the last clock of each bit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      bit_tick_o
);

    localparam int         CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_last;

    assign w_last = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = w_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick_o = en_i & w_last;

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// ============================================================================
//  Module : uart_tx_serializer
//  Brief  : UART transmitter, LSB first, registered tx line. 8N1 by default,
//           8E1 when UART_TX_PARITY_EN is defined.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_tx_serializer_if.slave  bus
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_DATA_BIT = 3'(DATA_BITS - 1);

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [2:0]           bit_cnt_q;
    logic [2:0]           bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic                 tx_q;
    logic                 tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
    logic                 parity_d;
`endif

    logic w_accept;
    logic w_bit_tick;
    logic w_ready;
    logic w_busy;
    logic w_done;

    assign w_accept = (state_q == ST_IDLE) && bus.tx_start;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_accept),
        .en_i       (state_q != ST_IDLE),
        .bit_tick_o (w_bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            tx_q      <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    shreg_d   = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    parity_d  = ^bus.tx_data;
`endif
                end
            end
            ST_START: begin
                if (w_bit_tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The line level is chosen from the next state so tx is a clean register.
    always_comb begin
        tx_d    = LINE_IDLE;
        w_ready = (state_q == ST_IDLE);
        w_busy  = (state_q != ST_IDLE);
        w_done  = (state_q == ST_STOP) && w_bit_tick;
        case (state_d)
            ST_IDLE:   tx_d = LINE_IDLE;
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            ST_STOP:   tx_d = STOP_BIT;
            default:   tx_d = LINE_IDLE;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = w_ready;
    assign bus.tx_busy  = w_busy;
    assign bus.tx_done  = w_done;

endmodule

`default_nettype wire
